// File: rtl/sim_console_slave.sv
// Wishbone console/exit slave: CPU bytes go through a FWFT FIFO to a valid/ready sink,
// and the first EXIT write latches the firmware result code.
//   state  | meaning
//   S_IDLE | waiting for a request (a TXDATA write to a full FIFO also waits here)
//   S_RESP | ack or err is on the bus for this one cycle
module sim_console_slave #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        exit_valid_o,
  output logic [7:0]  exit_code_o
);

  localparam int unsigned N     = FIFO_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << N;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exit_valid_q;
  logic [7:0]  exit_code_q;
  logic        exit_set;

  logic [N:0]   count_q, count_d;
  logic [N-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]   mem_q [DEPTH];

  logic        req;
  logic        full;
  logic        push;
  logic        pop;
  logic [31:0] status;
  logic        unused_ok;

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

  assign req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign full = (count_q == (N+1)'(DEPTH));

  assign char_valid_o = (count_q != '0);
  assign char_o       = char_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign pop          = char_valid_o & char_ready_i;

  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_dat_o     = rdata_q;
  assign exit_valid_o = exit_valid_q;
  assign exit_code_o  = exit_code_q;

  always_comb begin
    status             = '0;
    status[7:0]        = exit_code_q;
    status[8]          = exit_valid_q;
    status[16 +: N+1]  = count_q;
    status[31]         = full;
  end

  // A TXDATA write to a full FIFO simply stays in S_IDLE; dropping cyc/stb aborts it.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    push     = 1'b0;
    exit_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          case (wb_adr_i[3:2])
            2'd0: begin
              if (wb_we_i && wb_sel_i[0]) begin
                if (!full) begin
                  push    = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_RESP;
                end
              end else begin
                ack_d   = 1'b1;
                state_d = S_RESP;
              end
            end
            2'd1: begin
              ack_d   = 1'b1;
              state_d = S_RESP;
              if (!wb_we_i) rdata_d = status;
            end
            2'd2: begin
              ack_d   = 1'b1;
              state_d = S_RESP;
              if (wb_we_i && wb_sel_i[0] && !exit_valid_q) exit_set = 1'b1;
              if (!wb_we_i) rdata_d = {24'h000000, exit_code_q};
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (exit_set) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= wb_dat_i[7:0];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (N+1)'(1);
    else if (!push && pop) count_d = count_q - (N+1)'(1);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + N'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + N'(1);
    end
  end

  // Storage needs no reset: char_o is masked while the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

endmodule

// File: tb/tb_sim_console_slave.sv
// Bench for sim_console_slave: bus driver queues expected terminations and console bytes,
// a negedge monitor pops and compares them whenever the DUT terminates or hands off a byte.
module tb_sim_console_slave;

  localparam int LAT_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic        char_valid;
  logic [7:0]  char_b;
  logic        char_ready = 1'b0;
  logic        exit_valid;
  logic [7:0]  exit_code;

  typedef struct {
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } resp_t;

  resp_t      exp_resp[$];
  logic [7:0] exp_chars[$];
  int         errors = 0;
  int         checks = 0;

  sim_console_slave #(.FIFO_DEPTH_LOG2(4)) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_sel_i     (wb_sel),
    .wb_we_i      (wb_we),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_dat_o     (wb_dat_r),
    .wb_ack_o     (wb_ack),
    .wb_err_o     (wb_err),
    .char_valid_o (char_valid),
    .char_o       (char_b),
    .char_ready_i (char_ready),
    .exit_valid_o (exit_valid),
    .exit_code_o  (exit_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle; optionally pulse char_ready for the request cycle so a pop pairs with the push.
  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, input logic rdy_pulse, output int lat);
    @(posedge clk); #1;
    wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    if (rdy_pulse) char_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(wb_ack || wb_err) && lat < LAT_MAX);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (rdy_pulse) char_ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input bit is_err);
    int lat;
    exp_resp.push_back('{is_err: is_err, chk_dat: 1'b0, dat: 32'h0});
    bus(adr, 1'b1, dat, sel, 1'b0, lat);
    check("wr_latency", lat, 1);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp_dat, input bit is_err);
    int lat;
    exp_resp.push_back('{is_err: is_err, chk_dat: 1'b1, dat: exp_dat});
    bus(adr, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("rd_latency", lat, 1);
  endtask

  task automatic tx(input logic [7:0] b, input logic rdy_pulse);
    int lat;
    exp_chars.push_back(b);
    exp_resp.push_back('{is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
    bus(32'h0, 1'b1, {24'hABCDEF, b}, 4'h1, rdy_pulse, lat);
    check("tx_latency", lat, 1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (char_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("fifo_drained", char_valid, 0);
  endtask

  initial begin : monitor
    bit    prev_term = 1'b0;
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_term = 1'b0;
      end else begin
        if (wb_ack || wb_err) begin
          check("term_not_consecutive", prev_term, 0);
          check("ack_err_exclusive", wb_ack & wb_err, 0);
          if (exp_resp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_term: got ack=%0b err=%0b expected none at %0t", wb_ack, wb_err, $time);
          end else begin
            e = exp_resp.pop_front();
            check("term_kind_err", wb_err, e.is_err);
            if (e.chk_dat) check("rdata", wb_dat_r, e.dat);
          end
        end
        prev_term = wb_ack | wb_err;
        if (char_valid && char_ready) begin
          if (exp_chars.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_char: got 0x%02h expected none at %0t", char_b, $time);
          end else begin
            check("char_order", char_b, exp_chars.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat;
    bit acked;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack, 0);
    check("rst_err", wb_err, 0);
    check("rst_dat", wb_dat_r, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char", char_b, 0);
    check("rst_exit_valid", exit_valid, 0);
    check("rst_exit_code", exit_code, 0);
    rst_n = 1'b1;

    // 1) simple console stream
    char_ready = 1'b1;
    tx(8'h41, 1'b0);
    tx(8'h42, 1'b0);
    tx(8'h43, 1'b0);
    wait_empty();

    // 2) fill, stall the 17th write, release by draining
    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) tx(8'h60 + 8'(i), 1'b0);
    rd(32'h4, 32'h8010_0000, 1'b0);
    exp_chars.push_back(8'h70);
    exp_resp.push_back('{is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
    @(posedge clk); #1;
    wb_adr = 32'h0; wb_we = 1'b1; wb_dat_w = 32'h70; wb_sel = 4'h1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    acked = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wb_ack) acked = 1'b1;
    end
    check("stall_no_ack", acked, 0);
    check("stall_char_valid", char_valid, 1);
    char_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wb_ack && lat < LAT_MAX);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check("stall_release_latency", lat, 2);
    wait_empty();

    // 3) steady state at count=5 with paired push/pop, pointers wrap
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) tx(8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      tx(8'(i * 7 + 3), 1'b1);
      if (i % 25 == 24) rd(32'h4, 32'h0005_0000, 1'b0);
    end
    char_ready = 1'b1;
    wait_empty();

    // 4) exit register, first code wins
    check("exit_valid_before", exit_valid, 0);
    wr(32'h8, 32'h0000_002A, 4'h1, 1'b0);
    check("exit_valid_set", exit_valid, 1);
    check("exit_code_set", exit_code, 8'h2A);
    wr(32'h8, 32'h0000_0007, 4'hF, 1'b0);
    check("exit_code_sticky", exit_code, 8'h2A);
    rd(32'h4, 32'h0000_012A, 1'b0);
    rd(32'h8, 32'h0000_002A, 1'b0);

    // 5) reserved address, masked TXDATA write, other accesses
    char_ready = 1'b0;
    rd(32'hC, 32'h0, 1'b1);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check("err_no_exit_change", exit_code, 8'h2A);
    wr(32'h0, 32'h0000_0099, 4'b1110, 1'b0);
    @(posedge clk); #1;
    check("sel_masked_no_push", char_valid, 0);
    rd(32'h0, 32'h0, 1'b0);
    wr(32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd(32'h4, 32'h0000_012A, 1'b0);

    // 6) reset in the middle of a stalled write
    for (int i = 0; i < 16; i++) tx(8'hC0 + 8'(i), 1'b0);
    @(posedge clk); #1;
    wb_adr = 32'h0; wb_we = 1'b1; wb_dat_w = 32'h77; wb_sel = 4'h1;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst6_ack", wb_ack, 0);
    check("rst6_err", wb_err, 0);
    check("rst6_dat", wb_dat_r, 0);
    check("rst6_char_valid", char_valid, 0);
    check("rst6_char", char_b, 0);
    check("rst6_exit_valid", exit_valid, 0);
    check("rst6_exit_code", exit_code, 0);
    exp_chars.delete();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(32'h4, 32'h0000_0000, 1'b0);
    char_ready = 1'b1;
    tx(8'h5A, 1'b0);
    wait_empty();

    repeat (4) @(posedge clk);
    #1;
    check("resp_queue_empty", exp_resp.size(), 0);
    check("char_queue_empty", exp_chars.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
